// File: rtl/fir_sample_writer_pkg.sv
// rtl/fir_sample_writer_pkg.sv - shared state type and width defaults for the FIR sample writer
package rtaudio_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 7;
  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_KICK,
    ST_GUARD,
    ST_WAIT,
    ST_OUTPUT
  } state_t;

endpackage

// File: rtl/fir_sample_writer_if.sv
// rtl/fir_sample_writer_if.sv - audio RAM write port and fir_filter control/result bus
interface fir_sample_writer_if import rtaudio_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  fir_reset;
  logic [ADDR_WIDTH-1:0] fir_start_addr;
  logic [ADDR_WIDTH-1:0] fir_last_addr;
  logic [DATA_WIDTH-1:0] fir_result;
  logic                  fir_done;

  modport master (
    output mem_addr, mem_wdata, mem_we,
    output fir_reset, fir_start_addr, fir_last_addr,
    input  fir_result, fir_done
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we,
    input  fir_reset, fir_start_addr, fir_last_addr,
    output fir_result, fir_done
  );

endinterface

// File: rtl/fir_sample_writer_sample_skid_reg.sv
// rtl/fir_sample_writer_sample_skid_reg.sv - one-entry pending sample buffer with sticky overflow
module sample_skid_reg import rtaudio_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  overflow
);

  // A push in the same cycle as a pop refills the slot, so it stays full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && (!full || pop)) begin
        data <= push_data;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_sample_writer.sv
// rtl/fir_sample_writer.sv - writes samples into the circular audio RAM and sequences fir_filter runs
module fir_sample_writer import rtaudio_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_TAPS   = 3,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic                  in_valid,
  fir_sample_writer_if.master   bus,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int FILL_W = ADDR_WIDTH + 1;
  localparam int CNT_W  = ($clog2(MAX_WAIT) < 1) ? 1 : $clog2(MAX_WAIT);
  localparam logic [FILL_W-1:0]     TAPS      = FILL_W'(NUM_TAPS);
  localparam logic [ADDR_WIDTH-1:0] BACK      = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [FILL_W-1:0]     fill;
  logic [FILL_W-1:0]     fill_next;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  pend_full;
  logic                  pend_push;
  logic                  pend_pop;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [DATA_WIDTH-1:0] take_data;

  // In IDLE the pending sample has priority; a simultaneous new sample takes its place.
  assign pend_pop  = (state == ST_IDLE) && pend_full;
  assign pend_push = in_valid && ((state != ST_IDLE) || pend_full);
  assign take_data = pend_full ? pend_data : in_sample;
  assign fill_next = (fill < TAPS) ? fill + 1'b1 : fill;

  sample_skid_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pending (
    .clk      (clk),
    .reset    (reset),
    .push     (pend_push),
    .push_data(in_sample),
    .pop      (pend_pop),
    .full     (pend_full),
    .data     (pend_data),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      wr_ptr             <= '0;
      fill               <= '0;
      wait_cnt           <= '0;
      bus.mem_addr       <= '0;
      bus.mem_wdata      <= '0;
      bus.mem_we         <= 1'b0;
      bus.fir_reset      <= 1'b0;
      bus.fir_start_addr <= '0;
      bus.fir_last_addr  <= '0;
      out_sample         <= '0;
      out_valid          <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend_full || in_valid) begin
            bus.mem_we         <= 1'b1;
            bus.mem_addr       <= wr_ptr;
            bus.mem_wdata      <= take_data;
            bus.fir_last_addr  <= wr_ptr;
            bus.fir_start_addr <= wr_ptr - BACK;
            state              <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          bus.mem_we <= 1'b0;
          wr_ptr     <= wr_ptr + 1'b1;
          fill       <= fill_next;
          if (fill_next < TAPS) begin
            out_sample <= '0;
            out_valid  <= 1'b1;
            state      <= ST_OUTPUT;
          end else begin
            bus.fir_reset <= 1'b1;
            state         <= ST_KICK;
          end
        end
        ST_KICK: begin
          bus.fir_reset <= 1'b0;
          state         <= ST_GUARD;
        end
        ST_GUARD: begin
          // The filter's done from its previous run may still be visible here.
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.fir_done) begin
            out_sample <= bus.fir_result;
            out_valid  <= 1'b1;
            state      <= ST_OUTPUT;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            out_sample  <= '0;
            out_valid   <= 1'b1;
            state       <= ST_OUTPUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_OUTPUT: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_writer.sv
// tb/tb_fir_sample_writer.sv - self-checking bench for fir_sample_writer with a behavioural filter and RAM model
module tb_fir_sample_writer;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int TAPS  = 3;
  localparam int MW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          overflow;
  logic          timeout_err;

  fir_sample_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fir_sample_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_TAPS  (TAPS),
    .MAX_WAIT  (MW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .bus        (bus),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int cyc; logic [AW-1:0] s; logic [AW-1:0] l; } kick_t;
  typedef struct { int cyc; logic [DW-1:0] d; } out_t;
  typedef struct {
    logic [DW-1:0] sample;
    int            delay;
    logic [DW-1:0] res;
    logic          warm;
    logic [AW-1:0] addr;
    logic [AW-1:0] start;
    logic [AW-1:0] last;
    logic [DW-1:0] out;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  wr_t   wrq[$];
  kick_t kickq[$];
  out_t  outq[$];

  logic [DW-1:0] ram [DEPTH];
  int            model_delay = 6;
  bit            model_sum = 1'b0;
  logic [DW-1:0] model_val = '0;
  int            age;
  int            done_cyc;

  logic [DW-1:0] hist[$];
  int            n_wr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [DW-1:0] window_sum(input logic [AW-1:0] start);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < TAPS; i++) s = s + ram[(int'(start) + i) % DEPTH];
    return s;
  endfunction

  // External world: audio RAM, a filter whose done stays high until two cycles after its reset, and monitors.
  initial begin
    bus.fir_done   = 1'b0;
    bus.fir_result = '0;
    age            = -1;
    done_cyc       = -1;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_we) begin
        ram[bus.mem_addr] = bus.mem_wdata;
        wrq.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
      end
      if (out_valid) outq.push_back('{cyc, out_sample});
      if (reset) begin
        bus.fir_done = 1'b0;
        age          = -1;
      end else if (bus.fir_reset) begin
        kickq.push_back('{cyc, bus.fir_start_addr, bus.fir_last_addr});
        age = 0;
      end else if (age >= 0) begin
        age++;
        if (age == 2) bus.fir_done = 1'b0;
        if (age == model_delay) begin
          bus.fir_result = model_sum ? window_sum(bus.fir_start_addr) : model_val;
          bus.fir_done   = 1'b1;
          done_cyc       = cyc;
          age            = -1;
        end
        if (age > 1000) age = -1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [DW-1:0] s, output int c);
    in_sample = s;
    in_valid  = 1'b1;
    c         = cyc;
    tick(1);
    in_valid  = 1'b0;
  endtask

  task automatic model_accept(input logic [DW-1:0] s, output logic [DW-1:0] e, output logic [AW-1:0] a);
    a = AW'(n_wr % DEPTH);
    n_wr++;
    hist.push_back(s);
    if (hist.size() > TAPS) void'(hist.pop_front());
    e = '0;
    if (n_wr >= TAPS) for (int i = 0; i < TAPS; i++) e = e + hist[i];
  endtask

  task automatic clear_q();
    wrq.delete();
    kickq.delete();
    outq.delete();
    done_cyc = -1;
  endtask

  task automatic wait_out(input int n, input int bound);
    int k = 0;
    while (outq.size() < n && k < bound) begin
      tick(1);
      k++;
    end
    check("out_wait", 64'(outq.size() >= n), 64'(1));
  endtask

  task automatic wait_kick(input int bound);
    int k = 0;
    while (kickq.size() == 0 && k < bound) begin
      tick(1);
      k++;
    end
    check("kick_wait", 64'(kickq.size() > 0), 64'(1));
  endtask

  task automatic simple_run(input string tag, input logic [DW-1:0] s);
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    int            c;
    clear_q();
    model_accept(s, e, a);
    drive(s, c);
    wait_out(1, 300);
    if (outq.size() > 0) check({tag, "_out"}, 64'(outq[0].d), 64'(e));
    if (wrq.size() > 0) check({tag, "_addr"}, 64'(wrq[0].a), 64'(a));
  endtask

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] s;
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    int            c;

    vecs[0] = '{16'd5,      6,  16'h0000, 1'b1, 7'd0, 7'd0, 7'd0, 16'h0000};
    vecs[1] = '{16'd7,      6,  16'h0000, 1'b1, 7'd1, 7'd0, 7'd0, 16'h0000};
    vecs[2] = '{16'd9,      6,  16'h1234, 1'b0, 7'd2, 7'd0, 7'd2, 16'h1234};
    vecs[3] = '{16'd100,    3,  16'hBEEF, 1'b0, 7'd3, 7'd1, 7'd3, 16'hBEEF};
    vecs[4] = '{16'd200,    20, 16'h0042, 1'b0, 7'd4, 7'd2, 7'd4, 16'h0042};
    vecs[5] = '{16'hFFFF,   9,  16'hA5A5, 1'b0, 7'd5, 7'd3, 7'd5, 16'hA5A5};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    tick(3);
    check("reset_outputs", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.fir_reset,
                                bus.fir_start_addr, bus.fir_last_addr, out_sample, out_valid}), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    check("reset_timeout", 64'(timeout_err), 64'(0));
    reset = 1'b0;
    tick(2);

    // Warm-up, first filter run and follow-on runs with fixed filter results.
    model_sum = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clear_q();
      model_val   = vecs[i].res;
      model_delay = vecs[i].delay;
      model_accept(vecs[i].sample, e, a);
      drive(vecs[i].sample, c);
      wait_out(1, 300);
      check("vec_wr_count", 64'(wrq.size()), 64'(1));
      if (wrq.size() > 0) begin
        check("vec_wr_addr", 64'(wrq[0].a), 64'(vecs[i].addr));
        check("vec_wr_data", 64'(wrq[0].d), 64'(vecs[i].sample));
        check("vec_wr_latency", 64'(wrq[0].cyc - c), 64'(1));
      end
      if (vecs[i].warm) begin
        check("vec_warm_no_kick", 64'(kickq.size()), 64'(0));
      end else begin
        check("vec_kick_count", 64'(kickq.size()), 64'(1));
        if (kickq.size() > 0) begin
          check("vec_start_addr", 64'(kickq[0].s), 64'(vecs[i].start));
          check("vec_last_addr", 64'(kickq[0].l), 64'(vecs[i].last));
        end
        if (outq.size() > 0) check("vec_done_latency", 64'(outq[0].cyc - done_cyc), 64'(1));
      end
      if (outq.size() > 0) check("vec_out", 64'(outq[0].d), 64'(vecs[i].out));
    end

    // Random samples; sometimes a second one arrives mid-run and must wait in pending.
    model_sum = 1'b1;
    for (int it = 0; it < 30; it++) begin
      logic [DW-1:0] eo[2];
      logic [AW-1:0] ea[2];
      logic [DW-1:0] ed[2];
      int            nexp;
      clear_q();
      model_delay = int'($urandom_range(20, 3));
      s = DW'($urandom);
      ed[0] = s;
      model_accept(s, eo[0], ea[0]);
      drive(s, c);
      nexp = 1;
      tick(int'($urandom_range(15, 0)));
      if ($urandom_range(1, 0) == 1) begin
        s = DW'($urandom);
        ed[1] = s;
        model_accept(s, eo[1], ea[1]);
        drive(s, c);
        nexp = 2;
      end
      wait_out(nexp, 400);
      for (int j = 0; j < nexp; j++) begin
        if (j < outq.size()) check("rnd_out", 64'(outq[j].d), 64'(eo[j]));
        if (j < wrq.size()) begin
          check("rnd_wr_addr", 64'(wrq[j].a), 64'(ea[j]));
          check("rnd_wr_data", 64'(wrq[j].d), 64'(ed[j]));
        end
      end
    end

    // Two samples during WAIT: the first is kept, the second is dropped.
    check("ovf_before", 64'(overflow), 64'(0));
    begin
      logic [DW-1:0] e50;
      logic [DW-1:0] e11;
      clear_q();
      model_delay = 15;
      model_accept(16'd50, e50, a);
      drive(16'd50, c);
      wait_kick(50);
      tick(3);
      model_accept(16'd11, e11, a);
      drive(16'd11, c);
      drive(16'd12, c);
      check("ovf_set", 64'(overflow), 64'(1));
      wait_out(2, 400);
      if (outq.size() > 1) begin
        check("ovf_out_first", 64'(outq[0].d), 64'(e50));
        check("ovf_out_pending", 64'(outq[1].d), 64'(e11));
      end
      tick(10);
      check("ovf_wr_count", 64'(wrq.size()), 64'(2));
      if (wrq.size() > 1) check("ovf_wr_pending", 64'(wrq[1].d), 64'(11));
      check("ovf_sticky", 64'(overflow), 64'(1));
    end

    // Filter never answers: WAIT lasts MW cycles after GUARD, then a zero result.
    check("tmo_before", 64'(timeout_err), 64'(0));
    clear_q();
    model_delay = -1;
    model_accept(16'd77, e, a);
    drive(16'd77, c);
    wait_out(1, 400);
    check("tmo_flag", 64'(timeout_err), 64'(1));
    if (outq.size() > 0) check("tmo_out", 64'(outq[0].d), 64'(0));
    if (outq.size() > 0 && kickq.size() > 0)
      check("tmo_cycles", 64'(outq[0].cyc - (kickq[0].cyc + 1)), 64'(MW + 1));

    // Fill to the end of the buffer, then the next sample wraps to address 0.
    model_delay = 3;
    while (n_wr < DEPTH) simple_run("fill", DW'($urandom));
    clear_q();
    s = DW'($urandom);
    model_accept(s, e, a);
    drive(s, c);
    wait_out(1, 300);
    if (wrq.size() > 0) check("wrap_wr_addr", 64'(wrq[0].a), 64'(0));
    if (kickq.size() > 0) begin
      check("wrap_start_addr", 64'(kickq[0].s), 64'(DEPTH - (TAPS - 1)));
      check("wrap_last_addr", 64'(kickq[0].l), 64'(0));
    end
    if (outq.size() > 0) check("wrap_out", 64'(outq[0].d), 64'(e));
    check("sticky_overflow_late", 64'(overflow), 64'(1));
    check("sticky_timeout_late", 64'(timeout_err), 64'(1));

    // Reset in the middle of WAIT aborts the run and restarts warm-up at address 0.
    clear_q();
    model_delay = 30;
    model_accept(16'h0999, e, a);
    drive(16'h0999, c);
    wait_kick(50);
    tick(5);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.fir_reset,
                                  bus.fir_start_addr, bus.fir_last_addr, out_sample, out_valid}), 64'(0));
    check("rst_mid_overflow", 64'(overflow), 64'(0));
    check("rst_mid_timeout", 64'(timeout_err), 64'(0));
    tick(2);
    reset = 1'b0;
    hist.delete();
    n_wr = 0;
    outq.delete();
    tick(40);
    check("rst_no_out", 64'(outq.size()), 64'(0));
    clear_q();
    model_accept(16'h0055, e, a);
    drive(16'h0055, c);
    wait_out(1, 300);
    if (wrq.size() > 0) check("rst_wr_addr", 64'(wrq[0].a), 64'(0));
    check("rst_warm_no_kick", 64'(kickq.size()), 64'(0));
    if (outq.size() > 0) check("rst_warm_out", 64'(outq[0].d), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sample_writer.md
Name: fir_sample_writer

Overview:
- Producer side of the FIR sample-memory interface.
- Writes incoming audio samples into the circular audio RAM that fir_filter reads from.
- Computes the window start_addr/last_addr for each new sample, pulses the filter's reset to start a run, and waits for done.
- Returns each filtered result as a one-cycle valid strobe. Sits between the codec sample stream and fir_filter.

Parameters:
- ADDR_WIDTH, 7, audio RAM address width; the buffer depth is 2^ADDR_WIDTH entries.
- DATA_WIDTH, 16, sample and result width.
- NUM_TAPS, 3, window length; legal range is 1 to 2^ADDR_WIDTH.
- MAX_WAIT, 64, number of cycles allowed for fir_done before a timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_sample  in  DATA_WIDTH  new audio sample.
- in_valid  in  1  one-cycle strobe; in_sample is valid in this cycle.
- mem_addr  out  ADDR_WIDTH  write address for the audio RAM write port.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_we  out  1  write enable.
- fir_reset  out  1  start pulse to fir_filter (its reset input).
- fir_start_addr  out  ADDR_WIDTH  oldest sample of the window.
- fir_last_addr  out  ADDR_WIDTH  newest sample of the window.
- fir_result  in  DATA_WIDTH  filter result.
- fir_done  in  1  filter finished.
- out_sample  out  DATA_WIDTH  filtered sample.
- out_valid  out  1  one-cycle strobe for out_sample.
- overflow  out  1  sticky: an input sample was dropped.
- timeout_err  out  1  sticky: fir_done never arrived.

Behaviour:
- Reset values: all outputs 0, wr_ptr 0, fill count 0, pending empty, state IDLE. Reset asserted mid-operation aborts any run immediately; no out_valid follows.
- IDLE:
  - If pending is full, consume it; otherwise consume in_valid. Either case latches the sample and goes to WRITE.
  - If both pending and in_valid are present, take pending and move the new sample into pending.
- WRITE (1 cycle):
  - mem_we=1, mem_addr=wr_ptr, mem_wdata=sample.
  - Capture fir_last_addr=wr_ptr and fir_start_addr=(wr_ptr-(NUM_TAPS-1)) mod 2^ADDR_WIDTH.
  - wr_ptr increments with wrap. fill saturates at NUM_TAPS.
  - If fill (post-increment) < NUM_TAPS, go to OUTPUT with result 0 (warm-up). Otherwise go to KICK.
- KICK (1 cycle): fir_reset=1. Addresses are held stable from KICK until leaving WAIT.
- GUARD (1 cycle): fir_done is ignored, because the filter is still clearing its stale done.
- WAIT:
  - A wait counter starts at 0.
  - If fir_done=1: latch fir_result and go to OUTPUT.
  - If the counter reaches MAX_WAIT-1 without done: set timeout_err, result 0, go to OUTPUT.
- OUTPUT (1 cycle): out_valid=1 with out_sample=result, then go to IDLE.
- Latency, RAM read enabled at the first possible cycle: in_valid → mem_we is 1 cycle; done sampled → out_valid is 1 cycle.
- Input outside IDLE: in_valid in any non-IDLE state goes into the single pending register. If pending is already full, the sample is dropped and overflow=1.
- Sticky flags: overflow and timeout_err clear only on reset.
- Arithmetic: address arithmetic is modulo 2^ADDR_WIDTH; samples pass through unmodified.

Decomposition:
- Shared package (rtaudio_pkg):
  - the state enum (IDLE, WRITE, KICK, GUARD, WAIT, OUTPUT);
  - ADDR_WIDTH and DATA_WIDTH defaults.
- One natural sub-module, sample_skid_reg: the one-entry pending buffer with its overflow flag. Everything else stays in the top module.

Test Plan:
- Warm-up: after reset, feed 5 then 7 (NUM_TAPS=3) → writes to addr 0 and 1; two out_valid pulses with out_sample=0; fir_reset never pulses.
- First run: feed 9 → write to addr 2; fir_reset pulses with start=0, last=2. The model asserts done 6 cycles later with fir_result=16'h1234 → out_sample=16'h1234, one cycle after done.
- Wrap-around: feed 129 samples in total → sample 129 writes addr 0 with fir_start_addr=126 and fir_last_addr=0.
- Pending/overflow: assert in_valid twice (values 11, 12) during WAIT → 11 is processed next, 12 is dropped, overflow=1 and stays set.
- Timeout: the model never asserts done → timeout_err=1 and out_valid with 0 exactly MAX_WAIT=64 cycles after GUARD.
- Reset mid-WAIT: assert reset → all outputs 0, no out_valid. The next sample writes addr 0 and re-enters warm-up.
